// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
// Package : vid_pkg
// Brief   : Shared timing defaults (640x480@60), FIFO word type and scan-out
//           state encoding for the video output path.
// Rev     : 1.0
// ============================================================================
package vid_pkg;

    localparam int   VID_H_ACTIVE    = 640;
    localparam int   VID_H_FP        = 16;
    localparam int   VID_H_SYNC      = 96;
    localparam int   VID_H_BP        = 48;
    localparam int   VID_V_ACTIVE    = 480;
    localparam int   VID_V_FP        = 10;
    localparam int   VID_V_SYNC      = 2;
    localparam int   VID_V_BP        = 33;
    localparam logic VID_SYNC_POL    = 1'b0;
    localparam int   VID_PIX_DIV     = 4;
    localparam int   VID_RGB_W       = 24;
    localparam int   VID_FIFO_AW     = 9;
    localparam int   VID_FULL_MARGIN = 4;

    typedef struct packed {
        logic                 start;
        logic [VID_RGB_W-1:0] rgb;
    } pix_t;

    typedef enum logic [1:0] {
        ST_SEEK        = 2'd0,
        ST_WAIT_RASTER = 2'd1,
        ST_RUN         = 2'd2
    } scan_state_e;

    function automatic int line_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module : vid_pix_fifo
// Brief  : Show-ahead synchronous FIFO; head is read combinationally from the
//          registered read pointer, pushes into a full FIFO are dropped.
// Rev    : 1.0
// ============================================================================
module vid_pix_fifo #(
    parameter int DW = 25,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic [AW:0]   used_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign used_o  = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (used_o == {1'b1, {AW{1'b0}}});
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vid_scan_out.sv
`default_nettype none
// ============================================================================
// Module : vid_scan_out
// Brief  : Buffers the mixer pixel stream, generates raster timing and locks
//          the FIFO head to the raster origin; registered RGB/sync/DE out.
// Rev    : 1.0
// ============================================================================
module vid_scan_out
    import vid_pkg::*;
#(
    parameter int   H_ACTIVE    = VID_H_ACTIVE,
    parameter int   H_FP        = VID_H_FP,
    parameter int   H_SYNC      = VID_H_SYNC,
    parameter int   H_BP        = VID_H_BP,
    parameter int   V_ACTIVE    = VID_V_ACTIVE,
    parameter int   V_FP        = VID_V_FP,
    parameter int   V_SYNC      = VID_V_SYNC,
    parameter int   V_BP        = VID_V_BP,
    parameter logic SYNC_POL    = VID_SYNC_POL,
    parameter int   PIX_DIV     = VID_PIX_DIV,
    parameter int   RGB_W       = VID_RGB_W,
    parameter int   FIFO_AW     = VID_FIFO_AW,
    parameter int   FULL_MARGIN = VID_FULL_MARGIN
) (
    input  logic             iCLOCK,
    input  logic             iRESET,
    input  logic             iPIX_START,
    input  logic [RGB_W-1:0] iPIX_RGB,
    input  logic             iPIX_WRITE,
    output logic             oPIX_FULL,
    output logic [RGB_W-1:0] oVID_RGB,
    output logic             oVID_HSYNC,
    output logic             oVID_VSYNC,
    output logic             oVID_DE,
    output logic             oVBLANK_START,
    output logic             oUNDERFLOW
);
    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int DEPTH   = 1 << FIFO_AW;

    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    // Same layout as pix_t, but sized by this instance's RGB_W.
    typedef struct packed {
        logic             start;
        logic [RGB_W-1:0] rgb;
    } word_t;

    word_t            fifo_din;
    word_t            fifo_head;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_used;
    logic             pop;

    assign fifo_din = {iPIX_START, iPIX_RGB};

    vid_pix_fifo #(
        .DW ($bits(word_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i   (iCLOCK),
        .rst_i   (iRESET),
        .push_i  (iPIX_WRITE),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .used_o  (fifo_used)
    );

    // ------------------------------------------------------------------
    // Pixel tick and raster counters
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [HW-1:0]    hcnt_q;
    logic [VW-1:0]    vcnt_q;
    logic             tick;

    assign tick = (div_q == '0);

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (tick) begin
                if (hcnt_q == H_LAST) begin
                    hcnt_q <= '0;
                    vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
                end else begin
                    hcnt_q <= hcnt_q + 1'b1;
                end
            end
        end
    end

    logic [31:0] h_pos;
    logic [31:0] v_pos;
    logic        active;
    logic        hsync_on;
    logic        vsync_on;
    logic        at_origin;
    logic        vblank_pos;

    assign h_pos      = 32'(hcnt_q);
    assign v_pos      = 32'(vcnt_q);
    assign active     = (h_pos < 32'(H_ACTIVE)) && (v_pos < 32'(V_ACTIVE));
    assign hsync_on   = (h_pos >= 32'(H_ACTIVE + H_FP)) && (h_pos < 32'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_on   = (v_pos >= 32'(V_ACTIVE + V_FP)) && (v_pos < 32'(V_ACTIVE + V_FP + V_SYNC));
    assign at_origin  = (hcnt_q == '0) && (vcnt_q == '0);
    assign vblank_pos = (hcnt_q == '0) && (v_pos == 32'(V_ACTIVE));

    // ------------------------------------------------------------------
    // Frame-lock state machine
    // ------------------------------------------------------------------
    scan_state_e      state_q;
    scan_state_e      state_d;
    logic             run_tick;
    logic [RGB_W-1:0] rgb_d;
    logic             uf_set;

    // The origin tick that releases WAIT_RASTER already displays pixel (0,0).
    assign run_tick = tick && active &&
                      ((state_q == ST_RUN) || ((state_q == ST_WAIT_RASTER) && at_origin));

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= ST_SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SEEK: begin
                if (tick && !fifo_empty && fifo_head.start) begin
                    state_d = ST_WAIT_RASTER;
                end
            end
            ST_WAIT_RASTER: begin
                if (tick && at_origin) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_tick && (fifo_empty || (fifo_head.start && !at_origin))) begin
                    state_d = ST_SEEK;
                end
            end
            default: state_d = ST_SEEK;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        rgb_d  = '0;
        uf_set = 1'b0;
        if (state_q == ST_SEEK) begin
            pop = tick && !fifo_empty && !fifo_head.start;
        end
        if (run_tick) begin
            if (fifo_empty) begin
                uf_set = 1'b1;
            end else begin
                pop    = 1'b1;
                rgb_d  = fifo_head.rgb;
                uf_set = fifo_head.start && !at_origin;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered video outputs
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] rgb_q;
    logic             de_q;
    logic             hs_q;
    logic             vs_q;
    logic             vblank_q;
    logic             underflow_q;
    logic             full_q;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rgb_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            vblank_q    <= 1'b0;
            underflow_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            if (tick) begin
                rgb_q <= rgb_d;
                de_q  <= active;
                hs_q  <= hsync_on ? SYNC_POL : ~SYNC_POL;
                vs_q  <= vsync_on ? SYNC_POL : ~SYNC_POL;
            end
            vblank_q    <= tick && vblank_pos;
            underflow_q <= underflow_q | uf_set;
            full_q      <= (32'(fifo_used) >= 32'(DEPTH - FULL_MARGIN));
        end
    end

    assign oVID_RGB      = rgb_q;
    assign oVID_DE       = de_q;
    assign oVID_HSYNC    = hs_q;
    assign oVID_VSYNC    = vs_q;
    assign oVBLANK_START = vblank_q;
    assign oUNDERFLOW    = underflow_q;
    assign oPIX_FULL     = full_q;

endmodule
`default_nettype wire

// File: doc/vid_scan_out.md
# vid_scan_out

Downstream neighbour of the video mixer. Buffers the mixer's pixel stream (start flag, RGB, write strobe; back-pressure via full) in a FIFO. Generates raster timing (H/V counters, sync, data enable). Frame-locks the FIFO head to the raster using the start-of-frame flag. Drives registered RGB, HSYNC, VSYNC and DE to the video PHY/encoder, all in the single system clock domain.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width in pixel ticks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width in lines
- SYNC_POL, 1'b0, active level of HSYNC/VSYNC
- PIX_DIV, 4, system clocks per pixel tick (≥1)
- RGB_W, 24, pixel width
- FIFO_AW, 9, FIFO address width (depth 2^FIFO_AW)
- FULL_MARGIN, 4, free entries remaining when iPIX_FULL asserts
- iCLOCK  in  1  system clock; one clock domain, all logic on rising edge
- iRESET  in  1  asynchronous, active-high reset
- iPIX_START  in  1  with iPIX_WRITE: first pixel of a frame
- iPIX_RGB  in  RGB_W  pixel data
- iPIX_WRITE  in  1  push strobe
- oPIX_FULL  out  1  back-pressure to mixer
- oVID_RGB  out  RGB_W  output pixel, 0 outside DE
- oVID_HSYNC / oVID_VSYNC  out  1  sync
- oVID_DE  out  1  data enable
- oVBLANK_START  out  1  one-clock pulse at first blanking line
- oUNDERFLOW  out  1  sticky; cleared by reset only

## Operation
- FIFO:
  - Entries {start, rgb}.
  - A push when the FIFO is truly full is dropped; no wrap corruption.
  - oPIX_FULL = (used ≥ 2^FIFO_AW − FULL_MARGIN).
  - Simultaneous push and pop: count unchanged.
- Tick:
  - Counter 0..PIX_DIV−1.
  - Tick when it is 0.
  - H/V counters and pops advance only on ticks.
- Counters:
  - hcnt 0..H_TOTAL−1; vcnt 0..V_TOTAL−1.
  - Active region: hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - HSYNC while H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC; VSYNC uses the same form on vcnt.
  - Widths: $clog2 of the totals.
- State machine {SEEK, WAIT_RASTER, RUN}:
  - SEEK (reset state):
    - Pop and discard while the head has start=0.
    - On a head with start=1, do not pop; go to WAIT_RASTER.
  - WAIT_RASTER: at the tick where hcnt=0, vcnt=0, go to RUN.
  - RUN:
    - Pop one entry per active tick and output its rgb.
    - If FIFO is empty at an active tick: output 0, set oUNDERFLOW, go to SEEK.
    - If a popped entry has start=1 at any position other than (0,0): output that pixel, set oUNDERFLOW, go to SEEK (mixer restarted).
- Outside RUN:
  - oVID_DE still follows the raster.
  - Data is 0.
  - Sync keeps running.
- oVBLANK_START: pulse at the tick where hcnt=0, vcnt=V_ACTIVE.

## Timing
- Reset values:
  - oVID_RGB=0, oVID_DE=0.
  - oVID_HSYNC=oVID_VSYNC=~SYNC_POL.
  - oVBLANK_START=0, oUNDERFLOW=0, oPIX_FULL=0.
  - FIFO empty; all counters 0; state SEEK.
- FIFO is show-ahead: head valid combinationally from the registered read pointer; pop takes effect next clock.
- Latency:
  - Push to visible at head: 1 clock.
  - oPIX_FULL is registered and updates 1 clock after the count changes; FULL_MARGIN≥2 absorbs this.
- Video outputs are registered together, 1 clock after the tick on which the counters held the displayed position. They hold for PIX_DIV clocks.
- Reset mid-frame: all outputs return to reset values asynchronously. Mixer data already in flight is discarded via SEEK.

## Structure
- Package vid_pkg:
  - default timing constants (640x480@60);
  - typedef pix_t {logic start; logic [RGB_W-1:0] rgb;};
  - state enum scan_state_e.
- Sub-module vid_pix_fifo:
  - show-ahead synchronous FIFO, parameters DW and AW;
  - outputs dout, empty, used count.
- Raster counters and FSM live in the top module.

## Test plan
- Small raster (H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, PIX_DIV=1):
  - Push 8 pixels, the first with start=1, values 1..8.
  - Required: DE runs 4 clocks/line; RGB sequence 1,2,3,4 then 5,6,7,8; HSYNC 1 tick after each active run; oUNDERFLOW=0.
- Leading junk: push 3 pixels with start=0, then a frame.
  - Required: the 3 are discarded; first displayed value = first start pixel.
- Underflow: push only 5 of 8 pixels.
  - Required: the 6th active position shows 0; oUNDERFLOW=1 and sticky; the next full frame displays correctly after reset of the frame via SEEK.
- Back-pressure: FIFO_AW=3, FULL_MARGIN=2, no raster pops.
  - Required: oPIX_FULL asserts after 6 pushes; the 9th push is dropped; the count stays 8.
- PIX_DIV=4:
  - Required: each pixel holds 4 clocks; oVBLANK_START is a single-clock pulse once per frame.
- Assert iRESET mid-line.
  - Required: outputs immediately at reset values; after release, the first frame starts at a start flag.
